// File: rtl/reduction_round_ctrl_if.sv
// Purpose : bundles the start/host-read/bank-control signals of reduction_round_ctrl.
// Latency : n/a (signal bundle only).
// Backpressure: none; the host read port is granted only while the sequencer is idle.
// Ports (master = sequencer side):
//   in : start, ext_rd_en, ext_rd_addr
//   out: ext_rd_gnt, busy, init_done, round_done, done, round_counter,
//        src_sel, res_sel, load_sel, rd_en, rd_addr, wr_en_A, wr_en_B, wr_addr
interface reduction_round_ctrl_if #(
    parameter int NUM_POWER = 5,
    parameter int RND_W     = 3
);
    logic                 start;
    logic                 ext_rd_en;
    logic [NUM_POWER-1:0] ext_rd_addr;
    logic                 ext_rd_gnt;
    logic                 busy;
    logic                 init_done;
    logic                 round_done;
    logic                 done;
    logic [RND_W-1:0]     round_counter;
    logic                 src_sel;
    logic                 res_sel;
    logic                 load_sel;
    logic                 rd_en;
    logic [NUM_POWER-1:0] rd_addr;
    logic                 wr_en_A;
    logic                 wr_en_B;
    logic [NUM_POWER-1:0] wr_addr;

    modport master (
        input  start, ext_rd_en, ext_rd_addr,
        output ext_rd_gnt, busy, init_done, round_done, done, round_counter,
               src_sel, res_sel, load_sel, rd_en, rd_addr, wr_en_A, wr_en_B, wr_addr
    );

    modport slave (
        output start, ext_rd_en, ext_rd_addr,
        input  ext_rd_gnt, busy, init_done, round_done, done, round_counter,
               src_sel, res_sel, load_sel, rd_en, rd_addr, wr_en_A, wr_en_B, wr_addr
    );
endinterface

// File: rtl/reduction_round_ctrl.sv
// Purpose : sequencer for the additive-FFT reduction datapath: INIT load into bank A, then
//           ROUNDS read/compute/write passes ping-ponging between banks A and B.
// Latency : start-to-done = DEPTH+1 + ROUNDS*(DEPTH+PIPE_LAT+1) cycles.
// Backpressure: none; start is ignored while busy, host reads are granted only in IDLE.
// Ports: clk, rst (sync, active-high) plus bus (reduction_round_ctrl_if.master).
module reduction_round_ctrl #(
    parameter int NUM_POWER = 5,
    parameter int ROUNDS    = 4,
    parameter int PIPE_LAT  = 2,
    parameter int RND_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    reduction_round_ctrl_if.master bus
);
    localparam int DEPTH = 2 ** NUM_POWER;
    // Cycles spent in ROUND: DEPTH read cycles followed by PIPE_LAT drain cycles.
    localparam int RLEN  = DEPTH + PIPE_LAT;
    localparam int CNT_W = $clog2(RLEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROUND, S_SWAP, S_DONE} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 busy_q;
    logic                 init_done_q;
    logic                 round_done_q;
    logic                 done_q;
    logic [RND_W-1:0]     rnd_q;
    logic                 src_q;
    logic                 res_q;
    logic                 load_q;
    logic                 rd_en_q;
    logic [NUM_POWER-1:0] rd_addr_q;
    // Write side is the read schedule delayed by the datapath latency.
    logic [PIPE_LAT-1:0]  wvld_q;
    logic [NUM_POWER-1:0] waddr_q [PIPE_LAT];

    logic                 idle;
    logic                 wr_vld;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            round_done_q <= 1'b0;
            done_q       <= 1'b0;
            rnd_q        <= '0;
            src_q        <= 1'b0;
            res_q        <= 1'b0;
            load_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            wvld_q       <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                waddr_q[i] <= '0;
            end
        end else begin
            wvld_q[0]  <= rd_en_q;
            waddr_q[0] <= rd_addr_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wvld_q[i]  <= wvld_q[i-1];
                waddr_q[i] <= waddr_q[i-1];
            end

            init_done_q  <= 1'b0;
            round_done_q <= 1'b0;
            done_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_INIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        load_q  <= 1'b1;
                    end
                end
                // cnt_q doubles as the INIT write address.
                S_INIT: begin
                    if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_q     <= S_ROUND;
                        cnt_q       <= '0;
                        load_q      <= 1'b0;
                        init_done_q <= 1'b1;
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_ROUND: begin
                    if (cnt_q == CNT_W'(RLEN - 1)) begin
                        state_q      <= S_SWAP;
                        round_done_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_inc;
                        rd_en_q <= (cnt_inc < CNT_W'(DEPTH));
                        if (cnt_inc < CNT_W'(DEPTH)) begin
                            rd_addr_q <= cnt_inc[NUM_POWER-1:0];
                        end
                    end
                end
                S_SWAP: begin
                    if (rnd_q != RND_W'(ROUNDS - 1)) begin
                        state_q   <= S_ROUND;
                        rnd_q     <= rnd_q + RND_W'(1);
                        src_q     <= ~src_q;
                        cnt_q     <= '0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end else begin
                        // The last round wrote into ~src, so that bank holds the result.
                        state_q <= S_DONE;
                        res_q   <= ~src_q;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    src_q   <= 1'b0;
                    rnd_q   <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign idle   = (state_q == S_IDLE);
    assign wr_vld = wvld_q[PIPE_LAT-1];

    // Host owns the read port only while idle.
    assign bus.ext_rd_gnt    = bus.ext_rd_en & idle;
    assign bus.rd_en         = idle ? bus.ext_rd_en   : rd_en_q;
    assign bus.rd_addr       = idle ? bus.ext_rd_addr : rd_addr_q;

    assign bus.busy          = busy_q;
    assign bus.init_done     = init_done_q;
    assign bus.round_done    = round_done_q;
    assign bus.done          = done_q;
    assign bus.round_counter = rnd_q;
    assign bus.src_sel       = src_q;
    assign bus.res_sel       = res_q;
    assign bus.load_sel      = load_q;

    // INIT and round writes never overlap, so the A/B enables stay exclusive.
    assign bus.wr_en_A       = load_q | (wr_vld & src_q);
    assign bus.wr_en_B       = wr_vld & ~src_q;
    assign bus.wr_addr       = load_q ? cnt_q[NUM_POWER-1:0] : waddr_q[PIPE_LAT-1];
endmodule
